// File: rtl/pit_table.sv
// Pending Interest Table: a direct-mapped table of outstanding interests keyed by a
// hashed name prefix, with one request in flight at a time and a valid/ready response.
module pit_table #(
  parameter int KEY_W      = 64,
  parameter int IDX_W      = 10,
  parameter int FACE_W     = 4,
  parameter int ADDR_W     = 32,
  parameter int BLOCK_SIZE = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [KEY_W-1:0]  req_key,
  input  logic [FACE_W-1:0] req_face,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [FACE_W-1:0] rsp_faces,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [IDX_W:0]    occupancy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BLOCK_SIZE);

  localparam logic [1:0] ST_INSERTED   = 2'b00;
  localparam logic [1:0] ST_AGGREGATED = 2'b01;
  localparam logic [1:0] ST_SATISFIED  = 2'b10;
  localparam logic [1:0] ST_REJECTED   = 2'b11;

  typedef enum logic [1:0] {INIT, IDLE, LOOKUP, RESP} state_t;

  state_t state;

  logic [DEPTH-1:0]  valid_mem;
  logic [KEY_W-1:0]  key_mem   [DEPTH];
  logic [FACE_W-1:0] faces_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];

  logic [IDX_W-1:0]  init_idx;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_op;
  logic [KEY_W-1:0]  cur_key;
  logic [FACE_W-1:0] cur_face;
  logic [ADDR_W-1:0] next_addr;

  logic              hit_valid;
  logic              key_match;
  logic [FACE_W-1:0] hit_faces;
  logic [ADDR_W-1:0] hit_addr;

  // Key bit i lands in index bit (i mod IDX_W): equivalent to XOR-folding IDX_W-bit
  // slices with the top partial slice zero-extended.
  function automatic logic [IDX_W-1:0] key_hash(input logic [KEY_W-1:0] key);
    logic [IDX_W-1:0] h;
    h = '0;
    for (int i = 0; i < KEY_W; i++) begin
      h[i % IDX_W] = h[i % IDX_W] ^ key[i];
    end
    return h;
  endfunction

  assign hit_valid = valid_mem[cur_idx];
  assign hit_faces = faces_mem[cur_idx];
  assign hit_addr  = addr_mem[cur_idx];
  assign key_match = hit_valid && (key_mem[cur_idx] == cur_key);

  // Table writes live in the non-reset branch so a reset in any state never
  // leaves a half-written entry behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_idx   <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_faces  <= '0;
      rsp_addr   <= '0;
      occupancy  <= '0;
      next_addr  <= '0;
    end else begin
      case (state)
        INIT: begin
          valid_mem[init_idx] <= 1'b0;
          init_idx            <= init_idx + 1'b1;
          if (&init_idx) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end

        IDLE: begin
          if (req_valid) begin
            cur_op    <= req_op;
            cur_key   <= req_key;
            cur_face  <= req_face;
            cur_idx   <= key_hash(req_key);
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end

        LOOKUP: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          if (!cur_op) begin
            if (key_match) begin
              faces_mem[cur_idx] <= hit_faces | cur_face;
              rsp_status         <= ST_AGGREGATED;
              rsp_faces          <= hit_faces | cur_face;
              rsp_addr           <= hit_addr;
            end else if (!hit_valid) begin
              valid_mem[cur_idx] <= 1'b1;
              key_mem[cur_idx]   <= cur_key;
              faces_mem[cur_idx] <= cur_face;
              addr_mem[cur_idx]  <= next_addr;
              next_addr          <= next_addr + STRIDE;
              occupancy          <= occupancy + 1'b1;
              rsp_status         <= ST_INSERTED;
              rsp_faces          <= cur_face;
              rsp_addr           <= next_addr;
            end else begin
              rsp_status <= ST_REJECTED;
              rsp_faces  <= '0;
              rsp_addr   <= '0;
            end
          end else begin
            if (key_match) begin
              valid_mem[cur_idx] <= 1'b0;
              occupancy          <= occupancy - 1'b1;
              rsp_status         <= ST_SATISFIED;
              rsp_faces          <= hit_faces;
              rsp_addr           <= hit_addr;
            end else begin
              rsp_status <= ST_REJECTED;
              rsp_faces  <= '0;
              rsp_addr   <= '0;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= INIT;
          init_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pit_table.sv
// Randomized scoreboard bench for pit_table: a dictionary-based model predicts each
// response at issue time; an independent monitor checks responses as they appear.
module tb_pit_table;

  localparam int KEY_W  = 64;
  localparam int IDX_W  = 10;
  localparam int FACE_W = 4;
  localparam int ADDR_W = 32;
  localparam int BLOCK  = 1024;
  localparam int DEPTH  = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_op = 1'b0;
  logic [KEY_W-1:0]  req_key = '0;
  logic [FACE_W-1:0] req_face = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_status;
  logic [FACE_W-1:0] rsp_faces;
  logic [ADDR_W-1:0] rsp_addr;
  logic [IDX_W:0]    occupancy;

  pit_table #(
    .KEY_W(KEY_W), .IDX_W(IDX_W), .FACE_W(FACE_W), .ADDR_W(ADDR_W), .BLOCK_SIZE(BLOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_face(req_face),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_faces(rsp_faces), .rsp_addr(rsp_addr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        status;
    logic [FACE_W-1:0] faces;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W:0]    occ;
    bit                care_fields;
  } exp_t;

  typedef struct {
    logic [KEY_W-1:0]  key;
    logic [FACE_W-1:0] faces;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  ent_t            tbl [int];
  logic [ADDR_W-1:0] m_next_addr = '0;
  int              m_occ = 0;
  exp_t            sb [$];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  force_low = 1'b0;
  logic [KEY_W-1:0] pool [8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int hashKey(input logic [KEY_W-1:0] k);
    logic [63:0] h;
    h = '0;
    for (int s = 0; s < KEY_W; s += IDX_W)
      h = h ^ ((64'(k) >> s) & ((64'd1 << IDX_W) - 64'd1));
    return int'(h);
  endfunction

  function automatic exp_t predict(input logic op, input logic [KEY_W-1:0] key,
                                   input logic [FACE_W-1:0] face);
    exp_t e;
    int   h;
    h = hashKey(key);
    e.care_fields = 1'b1;
    e.faces = '0;
    e.addr = '0;
    if (!op) begin
      if (tbl.exists(h) && tbl[h].key == key) begin
        tbl[h].faces = tbl[h].faces | face;
        e.status = 2'b01; e.faces = tbl[h].faces; e.addr = tbl[h].addr;
      end else if (!tbl.exists(h)) begin
        tbl[h] = '{key: key, faces: face, addr: m_next_addr};
        e.status = 2'b00; e.faces = face; e.addr = m_next_addr;
        m_next_addr = m_next_addr + ADDR_W'(BLOCK);
        m_occ++;
      end else begin
        e.status = 2'b11;
        e.care_fields = 1'b0;
      end
    end else begin
      if (tbl.exists(h) && tbl[h].key == key) begin
        e.status = 2'b10; e.faces = tbl[h].faces; e.addr = tbl[h].addr;
        tbl.delete(h);
        m_occ--;
      end else begin
        e.status = 2'b11;
      end
    end
    e.occ = (IDX_W+1)'(m_occ);
    return e;
  endfunction

  // Issue one request, wait for acceptance, then check the two-cycle response latency.
  task automatic applyStimulus(input logic op, input logic [KEY_W-1:0] key,
                               input logic [FACE_W-1:0] face);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_key = key; req_face = face;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) begin accepted = 1'b1; break; end
    end
    if (!accepted) begin
      checkOutput("req_accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(predict(op, key, face));
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("lookup_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("lookup_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    checkOutput("latency_rsp_valid", 64'(rsp_valid), 64'd1);
  endtask

  task automatic drainQueue();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic resetDut();
    int zeros;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    sb.delete();
    tbl.delete();
    m_occ = 0;
    m_next_addr = '0;
    #1 rst = 1'b0;
    zeros = 0;
    for (int i = 0; i < DEPTH + 100; i++) begin
      @(negedge clk);
      if (req_ready) break;
      zeros++;
    end
    checkOutput("init_ready_low_cycles", 64'(zeros), 64'(DEPTH));
    checkOutput("init_ready_rises", 64'(req_ready), 64'd1);
    checkOutput("init_occupancy", 64'(occupancy), 64'd0);
  endtask

  always begin
    @(posedge clk); #1;
    rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops on each accepted response and checks that stalled outputs hold.
  initial begin
    bit   held;
    logic [1:0]        h_status;
    logic [FACE_W-1:0] h_faces;
    logic [ADDR_W-1:0] h_addr;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin held = 1'b0; continue; end
      if (held) begin
        checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("hold_fields", {30'd0, rsp_status, rsp_faces, rsp_addr},
                    {30'd0, h_status, h_faces, h_addr});
      end
      if (rsp_valid && rsp_ready) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          checkOutput("unexpected_response", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_status", 64'(rsp_status), 64'(e.status));
          if (e.care_fields) begin
            checkOutput("rsp_faces", 64'(rsp_faces), 64'(e.faces));
            checkOutput("rsp_addr", 64'(rsp_addr), 64'(e.addr));
          end
          checkOutput("occupancy", 64'(occupancy), 64'(e.occ));
        end
      end else if (rsp_valid) begin
        held = 1'b1;
        h_status = rsp_status; h_faces = rsp_faces; h_addr = rsp_addr;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_fields", {30'd0, rsp_status, rsp_faces, rsp_addr}, 64'd0);
    checkOutput("reset_occupancy", 64'(occupancy), 64'd0);

    resetDut();

    // Insert, aggregate, satisfy, miss, collide, then prove next_addr did not move.
    applyStimulus(1'b0, 64'h1234, 4'b0001);
    applyStimulus(1'b0, 64'h5678, 4'b0010);
    applyStimulus(1'b0, 64'h1234, 4'b0100);
    applyStimulus(1'b1, 64'h1234, 4'b0000);
    applyStimulus(1'b1, 64'h1234, 4'b0000);
    applyStimulus(1'b0, 64'h1234, 4'b0001);
    applyStimulus(1'b0, 64'h1234 ^ (64'd1 << 10) ^ 64'd1, 4'b0010);
    applyStimulus(1'b0, 64'h9ABC, 4'b1000);

    pool[0] = 64'h1234;
    pool[1] = 64'h1635;
    pool[2] = 64'h5678;
    pool[3] = 64'h9ABC;
    pool[4] = {$urandom, $urandom};
    pool[5] = pool[4] ^ 64'h401;
    pool[6] = {$urandom, $urandom};
    pool[7] = {32'd0, $urandom};
    for (int t = 0; t < 300; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                    4'(1 << $urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Stall a response, then reset while it is pending.
    drainQueue();
    force_low = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(1'b0, 64'h0BAD_F00D, 4'b0100);
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_resp_rsp_valid", 64'(rsp_valid), 64'd0);
    force_low = 1'b0;
    resetDut();

    applyStimulus(1'b1, 64'h5678, 4'b0000);
    applyStimulus(1'b0, 64'h5678, 4'b0010);
    drainQueue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pit_table.md
PIT_TABLE -- requirements
Module: pit_table

Interface
REQ-001 Parameters, one per line: name, default, meaning.
 KEY_W, 64, name-prefix key width in bits.
 IDX_W, 10, table index width; depth = 2^IDX_W entries.
 FACE_W, 4, face bitmask width.
 ADDR_W, 32, content-store address width.
 BLOCK_SIZE, 1024, address stride per allocation.
REQ-002 Ports, one per line: name, direction, width, meaning.
 clk  in  1  clock
 rst  in  1  reset rst, synchronous, active-high; clock clk
 req_valid  in  1  request present
 req_ready  out  1  block can accept request
 req_op  in  1  0=interest, 1=data
 req_key  in  KEY_W  prefix key
 req_face  in  FACE_W  one-hot arrival face (interest only)
 rsp_valid  out  1  response present
 rsp_ready  in  1  consumer accepts response
 rsp_status  out  2  00=inserted, 01=aggregated, 10=satisfied, 11=rejected
 rsp_faces  out  FACE_W  face mask of the entry
 rsp_addr  out  ADDR_W  content-store address of the entry
 occupancy  out  IDX_W+1  count of valid entries

Function
REQ-003 Entry fields: valid(1), key(KEY_W), faces(FACE_W), addr(ADDR_W).
REQ-004 Hash: XOR of consecutive IDX_W-bit slices of req_key from bit 0 upward; the last partial slice is zero-extended.
REQ-005 FSM states: INIT, IDLE, LOOKUP, RESP.
REQ-006 INIT: write valid=0 to indices 0..2^IDX_W-1, one per cycle; exit to IDLE after the last index; req_ready=0 throughout.
REQ-007 req_ready=1 only in IDLE; handshake = req_valid && req_ready; request fields are captured on the handshake cycle.
REQ-008 LOOKUP: one cycle; reads the entry at the hash; determines status and performs the table update.
REQ-009 Interest with a valid entry whose key matches: faces |= req_face; status 01; rsp_faces = updated mask.
REQ-010 Interest with an invalid entry: write valid=1, key, faces=req_face, addr=next_addr; next_addr += BLOCK_SIZE (mod 2^ADDR_W); occupancy+1; status 00.
REQ-011 Interest with a valid entry whose key differs (collision): no table change; status 11.
REQ-012 Data with a valid, key-matching entry: return the entry's faces and addr; clear valid; occupancy-1; status 10.
REQ-013 Data with no matching entry: no table change; status 11; rsp_faces=0; rsp_addr=0.
REQ-014 RESP: rsp_valid=1; outputs are held stable until rsp_ready=1; then return to IDLE in the next cycle.
REQ-015 Latency: handshake at cycle N; rsp_valid is asserted at cycle N+2; minimum spacing between accepted requests is 3 cycles.
REQ-016 Rejected requests never modify next_addr or occupancy.
REQ-017 next_addr wraps silently; occupancy never exceeds 2^IDX_W.
REQ-018 rsp_ready has no effect outside RESP; req_valid has no effect outside IDLE.

Reset
REQ-019 rst sampled high at any cycle, including mid-LOOKUP or mid-RESP: the next state is INIT, any pending response is dropped, and there are no partial table writes.
REQ-020 Reset values: req_ready=0, rsp_valid=0, rsp_status=0, rsp_faces=0, rsp_addr=0, occupancy=0, next_addr=0.
REQ-021 After rst deasserts, req_ready first rises 2^IDX_W cycles later.

Verification
REQ-022 Reset release, IDX_W=10 -> req_ready=0 for 1024 cycles, then 1; occupancy=0.
REQ-023 Interest key=0x1234, face=0001 -> status 00, addr 0x0; second interest key=0x5678 (different hash), face=0010 -> status 00, addr 0x400; occupancy=2.
REQ-024 Interest key=0x1234, face=0100 after REQ-023 -> status 01, faces 0101, addr 0x0; occupancy unchanged.
REQ-025 Data key=0x1234 -> status 10, faces 0101, addr 0x0; a repeated data request for key=0x1234 -> status 11.
REQ-026 Interest key=0x1234, then interest with key=0x1234 ^ (1<<10) ^ 1 (same hash, different key) -> second response has status 11; next_addr is unchanged.
REQ-027 rsp_ready held low for 5 cycles -> rsp_valid and fields stay constant, req_ready=0; rst asserted during RESP -> rsp_valid=0 on the next cycle, and INIT re-runs.
